// File: rtl/common.sv
// Shared decode/execute types.
package common;

   // Decoded control word; the all-zero encoding is a NOP with no side effects.
   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
      logic       alu_src;
      logic [3:0] alu_op;
   } control_type;

endpackage

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: two-entry skid buffer between decode and execute.
// Beats are held in strict FIFO order; dec_ready and all outputs come from flops.
// Optional feature macro: ID_EX_STALL_CNT_EN adds the 32-bit stall_cycles counter.
module id_ex_pipeline_reg #(
   parameter int unsigned XLEN = 32
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [XLEN-1:0]                      dec_data1,
   input  logic [XLEN-1:0]                      dec_data2,
   input  logic [XLEN-1:0]                      dec_immediate_data,
   input  logic [$bits(common::control_type)-1:0] dec_control,
   input  logic                                 dec_compflg,
   input  logic [XLEN-1:0]                      dec_program_counter,
   input  logic                                 dec_valid,
   output logic                                 dec_ready,
   input  logic                                 flush,
   input  logic                                 ex_ready,
   output logic [XLEN-1:0]                      data1,
   output logic [XLEN-1:0]                      data2,
   output logic [XLEN-1:0]                      immediate_data,
   output logic [XLEN-1:0]                      program_counter_in,
   output common::control_type                  control_in,
   output logic                                 compflg_in,
   output logic                                 instr_valid_ex_in
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [31:0]                          stall_cycles
`endif
);

   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   state_e state_q;
   state_e state_d;

   logic up_xfer;
   logic down_xfer;
   logic load_out_dec;
   logic load_out_skd;
   logic load_skd;

   common::control_type dec_ctrl;

   logic [XLEN-1:0]     skd_data1;
   logic [XLEN-1:0]     skd_data2;
   logic [XLEN-1:0]     skd_imm;
   logic [XLEN-1:0]     skd_pc;
   common::control_type skd_ctrl;
   logic                skd_compflg;

   assign dec_ctrl  = common::control_type'(dec_control);
   assign up_xfer   = dec_valid && dec_ready;
   assign down_xfer = instr_valid_ex_in && ex_ready;

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next occupancy and datapath load strobes; flush overrides every transfer.
   always_comb begin
      state_d      = state_q;
      load_out_dec = 1'b0;
      load_out_skd = 1'b0;
      load_skd     = 1'b0;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (up_xfer) begin
                  load_out_dec = 1'b1;
                  state_d      = S_ONE;
               end
            end
            S_ONE: begin
               if (down_xfer && up_xfer) begin
                  load_out_dec = 1'b1;
               end else if (down_xfer) begin
                  state_d = S_EMPTY;
               end else if (up_xfer) begin
                  load_skd = 1'b1;
                  state_d  = S_TWO;
               end
            end
            S_TWO: begin
               if (down_xfer) begin
                  load_out_skd = 1'b1;
                  state_d      = S_ONE;
               end
            end
            default: begin
               state_d = S_EMPTY;
            end
         endcase
      end
   end

   // Registered handshake outputs derived from the next occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_ready         <= 1'b0;
         instr_valid_ex_in <= 1'b0;
      end else begin
         dec_ready         <= (state_d != S_TWO);
         instr_valid_ex_in <= (state_d != S_EMPTY);
      end
   end

   // Output payload register; control is forced to NOP whenever the output goes empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data1              <= '0;
         data2              <= '0;
         immediate_data     <= '0;
         program_counter_in <= '0;
         control_in         <= '0;
         compflg_in         <= 1'b0;
      end else begin
         if (load_out_dec) begin
            data1              <= dec_data1;
            data2              <= dec_data2;
            immediate_data     <= dec_immediate_data;
            program_counter_in <= dec_program_counter;
            control_in         <= dec_ctrl;
            compflg_in         <= dec_compflg;
         end else if (load_out_skd) begin
            data1              <= skd_data1;
            data2              <= skd_data2;
            immediate_data     <= skd_imm;
            program_counter_in <= skd_pc;
            control_in         <= skd_ctrl;
            compflg_in         <= skd_compflg;
         end
         if (state_d == S_EMPTY) begin
            control_in <= '0;
         end
      end
   end

   // Skid register capturing the beat accepted while the output is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skd_data1   <= '0;
         skd_data2   <= '0;
         skd_imm     <= '0;
         skd_pc      <= '0;
         skd_ctrl    <= '0;
         skd_compflg <= 1'b0;
      end else if (load_skd) begin
         skd_data1   <= dec_data1;
         skd_data2   <= dec_data2;
         skd_imm     <= dec_immediate_data;
         skd_pc      <= dec_program_counter;
         skd_ctrl    <= dec_ctrl;
         skd_compflg <= dec_compflg;
      end
   end

`ifdef ID_EX_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;

   // Saturating count of cycles where a valid output waits on execute; flush does not clear it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (instr_valid_ex_in && !ex_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_cnt_q;
`endif

endmodule
